// File: rtl/arbiter_pipelined_packet_if.sv
// Handshake bundle for the pipelined packet arbiter.
// Carries N request channels on the input side and one shared channel on the
// output side. The master modport is the arbiter's view. The slave modport is
// the view of the environment that feeds requests and drains the output.
`timescale 1ns/1ps
interface arbiter_pipelined_packet_if #(
    parameter int DWIDTH = 20,
    parameter int N      = 2
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]             in_valid;
    logic [N-1:0][DWIDTH-1:0] in_data;
    logic [N-1:0]             in_last;
    logic [N-1:0]             in_ready;

    logic                     out_valid;
    logic [DWIDTH-1:0]        out_data;
    logic                     out_last;
    logic [IDW-1:0]           out_src;
    logic                     out_ready;

    modport master (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output out_src,
        input  out_ready
    );

    modport slave (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_src,
        output out_ready
    );
endinterface

// File: rtl/arbiter_pipelined_packet.sv
// N-input, 1-output valid/ready arbiter with a registered output stage.
// Priority is either fixed, with a pointer that rotates on the shift input, or
// round-robin, where the last packet winner becomes the lowest priority.
// Multi-beat packets lock the arbiter to their source until the beat that
// carries in_last is accepted, so packets are never interleaved on the output.
// The output stage breaks the forward path. Only out_ready reaches in_ready
// combinationally.
`timescale 1ns/1ps
module arbiter_pipelined_packet #(
    parameter int DWIDTH           = 20,
    parameter int N                = 2,
    parameter int INIT_LOWEST_PRIO = N - 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic                        shift,
    arbiter_pipelined_packet_if.master  bus
);
    localparam int IDW = $clog2(N);

    // Registered state.
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [IDW-1:0]    out_src_q,   out_src_d;
    logic              lock_q,      lock_d;
    logic [IDW-1:0]    lock_id_q,   lock_id_d;
    logic [IDW-1:0]    ptr_q,       ptr_d;

    // Arbitration results for the current cycle.
    logic              load;
    logic              grant_valid;
    logic [IDW-1:0]    grant_idx;
    logic              accept;
    logic              accept_last;
    logic [N-1:0]      in_ready_c;
    int                cand;
    logic [IDW-1:0]    cand_idx;

    // The output stage can take a new beat when it is empty or being drained.
    assign load = !out_valid_q || bus.out_ready;

    // Choose the winner. A held lock admits only the locked source. Otherwise
    // the search starts just above the lowest-priority pointer and wraps upward.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (lock_q) begin
            if (bus.in_valid[lock_id_q]) begin
                grant_valid = 1'b1;
                grant_idx   = lock_id_q;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= N) begin
                    cand = cand - N;
                end
                cand_idx = IDW'(cand);
                if (!grant_valid && bus.in_valid[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

    // Raise a single ready for the winner. Ready stays low during reset, even
    // though the search above still sees valids.
    always_comb begin
        in_ready_c  = '0;
        accept      = rst && load && grant_valid;
        accept_last = bus.in_last[grant_idx];
        if (accept) begin
            in_ready_c[grant_idx] = 1'b1;
        end
    end

    assign bus.in_ready = in_ready_c;

    // Compute next state for the output stage, the packet lock and the pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
        ptr_d       = ptr_q;

        if (load) begin
            out_valid_d = accept;
        end

        if (accept) begin
            out_data_d = bus.in_data[grant_idx];
            out_last_d = accept_last;
            out_src_d  = grant_idx;
            lock_d     = !accept_last;
            lock_id_d  = grant_idx;
        end

        if (mode) begin
            if (accept && accept_last) begin
                ptr_d = grant_idx;
            end
        end else if (shift) begin
            ptr_d = (ptr_q == IDW'(N - 1)) ? '0 : ptr_q + IDW'(1);
        end
    end

    // State register. Reset drops any beat in flight and any held lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            ptr_q       <= IDW'(INIT_LOWEST_PRIO);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_arbiter_pipelined_packet.sv
// Directed bench for the pipelined packet arbiter: N=4, DWIDTH=20, INIT=3.
`timescale 1ns/1ps
module tb_arbiter_pipelined_packet;
    localparam int DWIDTH = 20;
    localparam int N      = 4;

    logic clk;
    logic rst;
    logic mode;
    logic shift;

    int assert_count;
    int fail_count;

    arbiter_pipelined_packet_if #(.DWIDTH(DWIDTH), .N(N)) bus ();

    arbiter_pipelined_packet #(
        .DWIDTH(DWIDTH),
        .N(N),
        .INIT_LOWEST_PRIO(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .shift(shift),
        .bus(bus)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the per-channel valid and last flags.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last);
        bus.in_valid = valid;
        bus.in_last  = last;
    endtask

    // Give each channel the default payload 0xA000<ch>.
    task automatic setDefaultData();
        for (int i = 0; i < N; i++) begin
            bus.in_data[i] = 20'hA0000 + 20'(i);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one rising edge.
    task automatic applyReset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
    endtask

    // Directed sequence of the reset, fixed, round-robin, lock,
    // backpressure and mid-packet-reset scenarios.
    initial begin
        int rr_exp[5];
        assert_count  = 0;
        fail_count    = 0;
        rst           = 1'b0;
        mode          = 1'b0;
        shift         = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(4'b1111, 4'b1111);
        setDefaultData();

        // Reset holds everything quiet even with all valids high.
        #2;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
        step();
        step();
        checkOutput("rst_hold_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("rst_out_src", 32'(bus.out_src), 32'h0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("rel_first_grant", 32'(bus.in_ready), 32'h1);
        step();
        checkOutput("rel_out_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("rel_out_src", 32'(bus.out_src), 32'h0);
        checkOutput("rel_out_data", 32'(bus.out_data), 32'hA0000);
        checkOutput("fixed_no_shift", 32'(bus.in_ready), 32'h1);

        // Fixed mode: one shift pulse moves the pointer from 3 to 0.
        shift = 1'b1;
        #1;
        checkOutput("shift_pre_grant", 32'(bus.in_ready), 32'h1);
        step();
        shift = 1'b0;
        #1;
        checkOutput("shift_src0", 32'(bus.out_src), 32'h0);
        checkOutput("shift_wrap_grant", 32'(bus.in_ready), 32'h2);
        step();
        checkOutput("shift_src1", 32'(bus.out_src), 32'h1);
        checkOutput("shift_data1", 32'(bus.out_data), 32'hA0001);
        step();
        checkOutput("shift_stays_ch1", 32'(bus.out_src), 32'h1);

        // Round robin, all valid, single-beat packets.
        mode = 1'b1;
        applyReset();
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("rr_valid_%0d", i), 32'(bus.out_valid), 32'h1);
            checkOutput($sformatf("rr_src_%0d", i), 32'(bus.out_src), 32'(rr_exp[i]));
            checkOutput($sformatf("rr_data_%0d", i), 32'(bus.out_data),
                        32'h000A0000 + 32'(rr_exp[i]));
        end

        // Packet lock: ch2 sends a 3-beat packet. Its valid drops for one
        // cycle mid-packet while ch0 waits.
        mode = 1'b0;
        applyStimulus(4'b0100, 4'b0000);
        bus.in_data[2] = 20'hB0001;
        applyReset();
        checkOutput("lock_b1_ready", 32'(bus.in_ready), 32'h4);
        step();
        checkOutput("lock_b1_src", 32'(bus.out_src), 32'h2);
        checkOutput("lock_b1_last", 32'(bus.out_last), 32'h0);
        applyStimulus(4'b0101, 4'b0000);
        bus.in_data[2] = 20'hB0002;
        #1;
        checkOutput("lock_b2_ready", 32'(bus.in_ready), 32'h4);
        step();
        checkOutput("lock_b2_src", 32'(bus.out_src), 32'h2);
        checkOutput("lock_b2_data", 32'(bus.out_data), 32'hB0002);
        applyStimulus(4'b0001, 4'b0000);
        #1;
        checkOutput("lock_drop_ready", 32'(bus.in_ready), 32'h0);
        step();
        checkOutput("lock_drop_bubble", 32'(bus.out_valid), 32'h0);
        applyStimulus(4'b0101, 4'b0100);
        bus.in_data[2] = 20'hB0003;
        #1;
        checkOutput("lock_b3_ready", 32'(bus.in_ready), 32'h4);
        step();
        checkOutput("lock_b3_src", 32'(bus.out_src), 32'h2);
        checkOutput("lock_b3_data", 32'(bus.out_data), 32'hB0003);
        checkOutput("lock_b3_last", 32'(bus.out_last), 32'h1);
        applyStimulus(4'b0001, 4'b0001);
        #1;
        checkOutput("unlock_ready", 32'(bus.in_ready), 32'h1);
        step();
        checkOutput("unlock_src", 32'(bus.out_src), 32'h0);
        checkOutput("unlock_valid", 32'(bus.out_valid), 32'h1);

        // Backpressure: the output holds for 5 cycles, then drains.
        mode = 1'b1;
        applyStimulus(4'b1111, 4'b1111);
        setDefaultData();
        applyReset();
        step();
        checkOutput("bp_first_src", 32'(bus.out_src), 32'h0);
        bus.out_ready = 1'b0;
        #1;
        checkOutput("bp_ready_low", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 32'h1);
            checkOutput($sformatf("bp_src_%0d", i), 32'(bus.out_src), 32'h0);
            checkOutput($sformatf("bp_data_%0d", i), 32'(bus.out_data), 32'hA0000);
            checkOutput($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(bus.in_ready), 32'h2);
        step();
        checkOutput("bp_next_src", 32'(bus.out_src), 32'h1);
        checkOutput("bp_next_data", 32'(bus.out_data), 32'hA0001);

        // Reset mid-packet: ch1 is locked on beat 2 of 4 when reset hits.
        mode = 1'b0;
        applyStimulus(4'b0010, 4'b0000);
        bus.in_data[1] = 20'hC0001;
        applyReset();
        step();
        bus.in_data[1] = 20'hC0002;
        step();
        checkOutput("mid_b2_src", 32'(bus.out_src), 32'h1);
        checkOutput("mid_b2_data", 32'(bus.out_data), 32'hC0002);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("mid_rst_src", 32'(bus.out_src), 32'h0);
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1111);
        #1;
        checkOutput("mid_after_grant", 32'(bus.in_ready), 32'h1);
        step();
        checkOutput("mid_after_src", 32'(bus.out_src), 32'h0);
        checkOutput("mid_after_data", 32'(bus.out_data), 32'hA0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end
endmodule
